// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU/DMA requester and data-memory signal bundle for data_mem_arbiter
//
// Purpose : groups the two requester ports (c = CPU, d = DMA) and the
//           data-memory port into one interface.
// Modports: master - arbiter side (takes requests and mem_rdata, drives
//                    ready/rvalid/rdata and the memory command)
//           slave  - requesters and memory side
// Signals : x_req/x_we/x_addr/x_wdata  request from port x (c or d)
//           x_ready                    request accepted this cycle
//           x_rvalid/x_rdata           read response for port x
//           mem_addr/mem_wdata         byte address and write data to memory
//           mem_mre/mem_mwe            memory read / write enable
//           mem_rdata                  read data registered by the memory
interface data_mem_arbiter_if #(
   parameter int BUS = 32
);
   logic           c_req;
   logic           c_we;
   logic [BUS-1:0] c_addr;
   logic [BUS-1:0] c_wdata;
   logic           c_ready;
   logic           c_rvalid;
   logic [BUS-1:0] c_rdata;

   logic           d_req;
   logic           d_we;
   logic [BUS-1:0] d_addr;
   logic [BUS-1:0] d_wdata;
   logic           d_ready;
   logic           d_rvalid;
   logic [BUS-1:0] d_rdata;

   logic [BUS-1:0] mem_addr;
   logic [BUS-1:0] mem_wdata;
   logic           mem_mre;
   logic           mem_mwe;
   logic [BUS-1:0] mem_rdata;

   modport master (
      input  c_req, c_we, c_addr, c_wdata,
      output c_ready, c_rvalid, c_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ready, d_rvalid, d_rdata,
      output mem_addr, mem_wdata, mem_mre, mem_mwe,
      input  mem_rdata
   );

   modport slave (
      output c_req, c_we, c_addr, c_wdata,
      input  c_ready, c_rvalid, c_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ready, d_rvalid, d_rdata,
      input  mem_addr, mem_wdata, mem_mre, mem_mwe,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port (CPU/DMA) arbiter in front of a single data memory
//
// Purpose : accepts one request at a time from port c or port d, issues it
//           to the memory for one cycle (CMD), and for reads returns the
//           memory data on the granted port one cycle later (RESP).
// Ports   : clk  - clock, all state on rising edge
//           rst  - asynchronous active-high reset
//           bus  - data_mem_arbiter_if.master (requester c, requester d, memory)
// Option  : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests go to
//           the port not granted last; otherwise port c has fixed priority.
module data_mem_arbiter #(
   parameter int BUS = 32
) (
   input  logic               clk,
   input  logic               rst,
   data_mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next;

   // Request captured at the accepting edge
   logic           r_we;
   logic [BUS-1:0] r_addr;
   logic [BUS-1:0] r_wdata;
   logic           r_gnt_d;

   logic           r_c_rvalid;
   logic           r_d_rvalid;
   logic [BUS-1:0] r_c_rdata;
   logic [BUS-1:0] r_d_rdata;

   logic           w_any_req;
   logic           w_gnt_d;
   logic           w_accept;
   logic           w_c_ready;
   logic           w_d_ready;
   logic           w_mre;
   logic           w_mwe;
   logic           w_rd_done;

   assign w_any_req = bus.c_req | bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
   // r_last_d = 1 means d was granted last, so c wins the next tie.
   // Reset value gives c priority first.
   logic r_last_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_d <= 1'b1;
      end else if (w_accept) begin
         r_last_d <= w_gnt_d;
      end
   end

   assign w_gnt_d = bus.d_req & (~bus.c_req | ~r_last_d);
`else
   assign w_gnt_d = bus.d_req & ~bus.c_req;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_c_ready = 1'b0;
      w_d_ready = 1'b0;
      w_mre     = 1'b0;
      w_mwe     = 1'b0;
      w_accept  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_accept  = 1'b1;
               w_c_ready = ~w_gnt_d;
               w_d_ready = w_gnt_d;
               w_next    = CMD;
            end
         end
         CMD: begin
            w_mre  = ~r_we;
            w_mwe  = r_we;
            w_next = r_we ? IDLE : RESP;
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_gnt_d <= 1'b0;
      end else if (w_accept) begin
         r_we    <= w_gnt_d ? bus.d_we    : bus.c_we;
         r_addr  <= w_gnt_d ? bus.d_addr  : bus.c_addr;
         r_wdata <= w_gnt_d ? bus.d_wdata : bus.c_wdata;
         r_gnt_d <= w_gnt_d;
      end
   end

   // The memory presents read data before the CMD->RESP edge, so the
   // response registers load on that edge and are valid throughout RESP.
   assign w_rd_done = (r_state == CMD) & ~r_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_c_rdata  <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_c_rvalid <= w_rd_done & ~r_gnt_d;
         r_d_rvalid <= w_rd_done & r_gnt_d;
         if (w_rd_done & ~r_gnt_d) begin
            r_c_rdata <= bus.mem_rdata;
         end
         if (w_rd_done & r_gnt_d) begin
            r_d_rdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.c_ready   = w_c_ready;
   assign bus.d_ready   = w_d_ready;
   assign bus.c_rvalid  = r_c_rvalid;
   assign bus.d_rvalid  = r_d_rvalid;
   assign bus.c_rdata   = r_c_rdata;
   assign bus.d_rdata   = r_d_rdata;

   // Address and write data come straight from the latch, so they hold
   // their last values outside CMD. Enables are decoded from state and
   // therefore fall as soon as reset clears it.
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_mre   = w_mre;
   assign bus.mem_mwe   = w_mwe;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

   logic clk;
   logic rst;

   data_mem_arbiter_if #(.BUS(32)) bus ();

   data_mem_arbiter #(.BUS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory model: registers read data and performs writes on the falling edge in CMD
   logic [31:0] mem     [64];
   logic [31:0] exp_mem [64];

   always @(negedge clk) begin
      if (bus.mem_mre) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      if (bus.mem_mwe) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: {port, data} pushed on each accepted read, popped on rvalid
   logic [32:0] exp_q [$];
   int          acc_port [$];
   int          acc_cyc  [$];
   int          mwe_cycles = 0;

   bit          m_p;
   bit          m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [32:0] m_e;

   task automatic sb_pop(input bit p, input logic [31:0] data);
      if (exp_q.size() == 0) begin
         check("sb_unexpected_rvalid", 1, 0);
      end else begin
         m_e = exp_q.pop_front();
         check("sb_port", {63'd0, p}, {63'd0, m_e[32]});
         check("sb_rdata", {32'd0, data}, {32'd0, m_e[31:0]});
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.c_ready || bus.d_ready) begin
            check("single_ready", {63'd0, bus.c_ready & bus.d_ready}, 64'd0);
            m_p     = bus.d_ready;
            m_we    = m_p ? bus.d_we    : bus.c_we;
            m_addr  = m_p ? bus.d_addr  : bus.c_addr;
            m_wdata = m_p ? bus.d_wdata : bus.c_wdata;
            acc_port.push_back(int'(m_p));
            acc_cyc.push_back(cyc);
            if (m_we) exp_mem[m_addr[7:2]] = m_wdata;
            else      exp_q.push_back({m_p, exp_mem[m_addr[7:2]]});
         end
         if (bus.c_rvalid) sb_pop(1'b0, bus.c_rdata);
         if (bus.d_rvalid) sb_pop(1'b1, bus.d_rdata);
         if (bus.mem_mwe)  mwe_cycles++;
      end
   end

   task automatic drive(input bit p, input bit req, input bit we,
                        input logic [31:0] addr, input logic [31:0] data);
      if (p) begin
         bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = data;
      end else begin
         bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = data;
      end
   endtask

   task automatic wait_ready(input bit p);
      int n;
      n = 0;
      @(negedge clk);
      while (!(p ? bus.d_ready : bus.c_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", {63'd0, n < 20}, 64'd1);
   endtask

   task automatic issue(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      drive(p, 1'b1, we, addr, data);
      wait_ready(p);
      @(posedge clk); #1;
      drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   int base;
   int n;

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 32'hA500_0000 | i;
         exp_mem[i] = 32'hA500_0000 | i;
      end
      mem[4]     = 32'hDEAD_BEEF;
      exp_mem[4] = 32'hDEAD_BEEF;
      bus.mem_rdata = 32'd0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_c_ready",  {63'd0, bus.c_ready},  0);
      check("rst_d_ready",  {63'd0, bus.d_ready},  0);
      check("rst_c_rvalid", {63'd0, bus.c_rvalid}, 0);
      check("rst_d_rvalid", {63'd0, bus.d_rvalid}, 0);
      check("rst_mre",      {63'd0, bus.mem_mre},  0);
      check("rst_mwe",      {63'd0, bus.mem_mwe},  0);
      check("rst_mem_addr", {32'd0, bus.mem_addr}, 0);
      check("rst_c_rdata",  {32'd0, bus.c_rdata},  0);
      @(posedge clk); #1 rst = 1'b0;

      // CPU read of word 4, cycle-by-cycle latency
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
      @(negedge clk);
      check("rd_c_ready", {63'd0, bus.c_ready}, 1);
      check("rd_d_ready", {63'd0, bus.d_ready}, 0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("cmd_mre",      {63'd0, bus.mem_mre},  1);
      check("cmd_mwe",      {63'd0, bus.mem_mwe},  0);
      check("cmd_mem_addr", {32'd0, bus.mem_addr}, 64'h10);
      check("cmd_c_ready",  {63'd0, bus.c_ready},  0);
      @(negedge clk);
      check("resp_c_rvalid", {63'd0, bus.c_rvalid}, 1);
      check("resp_c_rdata",  {32'd0, bus.c_rdata},  64'hDEADBEEF);
      check("resp_d_rvalid", {63'd0, bus.d_rvalid}, 0);
      check("resp_mre",      {63'd0, bus.mem_mre},  0);
      @(negedge clk);
      check("post_c_rvalid", {63'd0, bus.c_rvalid}, 0);

      // DMA write then readback
      base = mwe_cycles;
      issue(1'b1, 1'b1, 32'h20, 32'h1234_5678);
      repeat (3) @(negedge clk);
      check("wr_mwe_cycles", mwe_cycles - base, 1);
      issue(1'b1, 1'b0, 32'h20, 32'd0);
      repeat (3) @(negedge clk);
      check("d_readback", {32'd0, bus.d_rdata}, 64'h12345678);

      // Reset during CMD of a read aborts it; c gets the next tie
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h18, 32'd0);
      wait_ready(1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("abort_mre_before", {63'd0, bus.mem_mre}, 1);
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      check("abort_mre_async", {63'd0, bus.mem_mre}, 0);
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_c_rvalid", {63'd0, bus.c_rvalid}, 0);
      check("abort_mwe",      {63'd0, bus.mem_mwe},  0);
      base = acc_port.size();
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h14, 32'd0);
      n = 0;
      while (acc_port.size() == base && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_tie_timeout", {63'd0, n < 20}, 1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      if (acc_port.size() > base) check("abort_tie_grant", acc_port[base], 0);
      repeat (4) @(negedge clk);

      // Both ports hold reads across four accepts
      do_reset();
      base = acc_port.size();
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h14, 32'd0);
      n = 0;
      while (acc_port.size() < base + 4 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("tie_timeout", {63'd0, n < 60}, 1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int k = 0; k < 4; k++) begin
         if (acc_port.size() > base + k) begin
`ifdef ARB_ROUND_ROBIN_EN
            check($sformatf("tie_grant%0d", k), acc_port[base + k], k % 2);
`else
            check($sformatf("tie_grant%0d", k), acc_port[base + k], 0);
`endif
         end
      end
      repeat (4) @(negedge clk);

      // c requests while d is in RESP; then back-to-back c reads
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 32'h14, 32'd0);
      wait_ready(1'b1);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
      @(negedge clk);
      check("resp_c_ready_low", {63'd0, bus.c_ready}, 0);
      check("resp_d_rvalid",    {63'd0, bus.d_rvalid}, 1);
      @(negedge clk);
      check("idle_c_ready_high", {63'd0, bus.c_ready}, 1);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h24, 32'd0);
      wait_ready(1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      n = acc_cyc.size();
      if (n >= 3) begin
         check("d_to_c_spacing", acc_cyc[n-2] - acc_cyc[n-3], 3);
         check("c_to_c_spacing", acc_cyc[n-1] - acc_cyc[n-2], 3);
      end else begin
         check("spacing_accepts", n, 3);
      end

      repeat (6) @(negedge clk);
      check("sb_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter BUS, default 32, giving the data and address width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports c_req, c_we (input, 1), c_addr, c_wdata (input, BUS), c_ready, c_rvalid (output, 1) and c_rdata (output, BUS), the CPU requester port (c).
REQ-005 The block SHALL have ports d_req, d_we, d_addr, d_wdata, d_ready, d_rvalid and d_rdata, identical in direction and width to port c, the DMA requester port (d).
REQ-006 The block SHALL have ports mem_addr, mem_wdata (output, BUS), mem_mre, mem_mwe (output, 1) and mem_rdata (input, BUS), driving one data memory: byte address, write data, read enable, write enable, and read data registered by the memory on clk.

Function
REQ-007 The block SHALL implement FSM states IDLE, CMD and RESP.
REQ-008 In IDLE with any request pending, the block SHALL combinationally raise x_ready for exactly one granted port; at the edge, it SHALL latch that port's we, addr and wdata and the grant id, then go to CMD.
REQ-009 A requester SHALL hold x_req, x_we, x_addr and x_wdata stable until it sees x_ready high; the block SHALL never raise x_ready outside IDLE.
REQ-010 In CMD, the block SHALL drive mem_addr and mem_wdata from the latched values, drive mem_mre = !we and mem_mwe = we, and go to RESP for a read or to IDLE for a write.
REQ-011 In IDLE and RESP, mem_mre and mem_mwe SHALL be 0 and mem_addr and mem_wdata SHALL hold their last values.
REQ-012 In RESP, the block SHALL raise the granted x_rvalid for one cycle with x_rdata = mem_rdata, then return to IDLE.
REQ-013 Read latency from the accepting edge to rvalid high SHALL be 2 cycles; an accepted write SHALL complete in 1 cycle. The memory writes on the falling edge inside CMD.
REQ-014 x_rdata SHALL be a register updated only in RESP for the granted port; the other port's rdata and rvalid SHALL be unchanged and 0 respectively.
REQ-015 The block SHALL pass addresses through unmodified; word alignment (addr[BUS-1:2]) is the memory's job, and addr[1:0] SHALL be ignored.
REQ-016 With only one port requesting in IDLE, that port SHALL be granted.
REQ-017 With both ports requesting in the same IDLE cycle, the grant SHALL follow REQ-022.
REQ-018 A request that drops before ready SHALL be treated as withdrawn, with no memory access.

Reset
REQ-019 While rst is high, the FSM SHALL be IDLE, all x_ready and x_rvalid SHALL be 0, mem_mre and mem_mwe SHALL be 0, and mem_addr, mem_wdata, x_rdata and the latched request SHALL be 0.
REQ-020 Reset asserted in CMD or RESP SHALL abort the access immediately: no rvalid, and the enables drop asynchronously.
REQ-021 Reset SHALL set the round-robin pointer so that port c has priority next.

Configuration
REQ-022 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the port not granted last, and the pointer SHALL update on every accept; without it, port c SHALL always win (fixed priority) and no pointer SHALL be built.

Verification
REQ-023 Reset, then c read at addr 0x10 with memory word 4 = 0xDEADBEEF -> c_ready 1 cycle, mem_mre=1 mem_addr=0x10 next cycle, c_rvalid=1 c_rdata=0xDEADBEEF on cycle +2; d_rvalid stays 0.
REQ-024 d write addr 0x20 data 0x12345678, then d read 0x20 -> mem_mwe high exactly 1 cycle, readback 0x12345678.
REQ-025 c and d both hold read requests for 4 accepts -> grants c,d,c,d with ARB_ROUND_ROBIN_EN; c,c,c,c without it, and d never ready.
REQ-026 rst pulsed during CMD of a read -> mem_mre drops at once, no rvalid, FSM IDLE, next both-request grant goes to c.
REQ-027 c_req raised while d is in RESP -> c_ready stays 0 until IDLE, then c accepted; back-to-back reads are spaced 3 cycles apart.
